// File: rtl/lane_rr_scheduler_pkg.sv
// Shared constants and the round-robin priority helper for the four-lane merge scheduler.
package lane_rr_scheduler_pkg;

  localparam int NLANES    = 4;
  localparam int LANE_W    = 2;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef logic [LANE_W-1:0] lane_t;

  // First requesting lane strictly after 'last', wrapping; 'last' itself is lowest priority.
  function automatic lane_t rr_next(input lane_t last, input logic [NLANES-1:0] req);
    lane_t idx;
    rr_next = last;
    for (int k = NLANES; k >= 1; k--) begin
      idx = last + LANE_W'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/lane_rr_scheduler_if.sv
// Lane inputs, consumer handshake and status bundle of the lane merge scheduler.
interface lane_rr_scheduler_if
  import lane_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [NLANES-1:0] validin;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [LANE_W-1:0] lane_out;
  logic [NLANES-1:0] fifo_empty;
  logic [NLANES-1:0] fifo_full;
  logic [NLANES-1:0] overflow;

  modport master (
    output in0, in1, in2, in3, validin, ready_in,
    input  data_out, valid_out, lane_out, fifo_empty, fifo_full, overflow
  );

  modport slave (
    input  in0, in1, in2, in3, validin, ready_in,
    output data_out, valid_out, lane_out, fifo_empty, fifo_full, overflow
  );
endinterface

// File: rtl/lane_rr_scheduler_lane_fifo.sv
// Per-lane byte FIFO: combinational head read, push accepted when full if a pop happens the same edge.
module lane_fifo
  import lane_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lane_rr_scheduler.sv
// Merges four byte lanes through per-lane FIFOs and a round-robin arbiter into one registered valid/ready output.
module lane_rr_scheduler
  import lane_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic                 clk,
  input logic                 reset,
  lane_rr_scheduler_if.slave  bus
);
  logic [DATA_W-1:0] lane_din  [NLANES];
  logic [DATA_W-1:0] lane_dout [NLANES];
  logic [NLANES-1:0] empty, full, pop;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  lane_t             lane_q, lane_d;
  lane_t             last_grant_q, last_grant_d;
  logic [NLANES-1:0] overflow_q, overflow_d;

  logic              load, any_req;
  lane_t             grant;

  assign lane_din[0] = bus.in0;
  assign lane_din[1] = bus.in1;
  assign lane_din[2] = bus.in2;
  assign lane_din[3] = bus.in3;

  assign load    = !valid_q || bus.ready_in;
  assign any_req = |(~empty);
  assign grant   = rr_next(last_grant_q, ~empty);

  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      assign pop[gi] = load && any_req && (grant == LANE_W'(gi));

      lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.validin[gi]),
        .din   (lane_din[gi]),
        .pop   (pop[gi]),
        .dout  (lane_dout[gi]),
        .empty (empty[gi]),
        .full  (full[gi])
      );
    end
  endgenerate

  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    lane_d       = lane_q;
    last_grant_d = last_grant_q;
    // A drop happens only when the lane is full and is not draining on the same edge.
    overflow_d   = overflow_q | (bus.validin & full & ~pop);
    if (load) begin
      if (any_req) begin
        data_d       = lane_dout[grant];
        lane_d       = grant;
        valid_d      = 1'b1;
        last_grant_d = grant;
      end else begin
        valid_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      lane_q       <= '0;
      last_grant_q <= LANE_W'(NLANES - 1);
      overflow_q   <= '0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      lane_q       <= lane_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.lane_out   = lane_q;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Self-checking bench: queue-based reference of the lane merge scheduler, directed scenarios plus random traffic.
module tb_lane_rr_scheduler;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_rr_scheduler_if #(.DATA_W(8)) bus ();

  lane_rr_scheduler #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: one queue per lane, output register and rotating priority pointer.
  logic [7:0] mq [4][$];
  logic [7:0] m_data;
  logic       m_valid;
  int         m_lane;
  int         m_last;
  logic [3:0] m_ovf;

  function automatic logic [7:0] lane_in(input int i);
    case (i)
      0:       return bus.in0;
      1:       return bus.in1;
      2:       return bus.in2;
      default: return bus.in3;
    endcase
  endfunction

  always @(posedge clk) begin
    int g;
    int l;
    g = -1;
    if (reset) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_lane  = 0;
      m_last  = 3;
      m_ovf   = 4'h0;
    end else begin
      if (!m_valid || bus.ready_in) begin
        for (int k = 1; k <= 4; k++) begin
          l = (m_last + k) % 4;
          if (g < 0 && mq[l].size() > 0) g = l;
        end
        if (g >= 0) begin
          m_data  = mq[g].pop_front();
          m_lane  = g;
          m_valid = 1'b1;
          m_last  = g;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.validin[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(lane_in(i));
          else m_ovf[i] = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e_empty, e_full;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        e_empty[i] = (mq[i].size() == 0);
        e_full[i]  = (mq[i].size() == DEPTH);
      end
      n_vec++;
      cmp("valid_out", 32'(bus.valid_out), 32'(m_valid));
      cmp("data_out", 32'(bus.data_out), 32'(m_data));
      cmp("lane_out", 32'(bus.lane_out), 32'(m_lane));
      cmp("fifo_empty", 32'(bus.fifo_empty), 32'(e_empty));
      cmp("fifo_full", 32'(bus.fifo_full), 32'(e_full));
      cmp("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int prev;
    logic [7:0] s0, s3;
    reset = 1'b1;
    bus.validin  = 4'hF;
    bus.in0 = 8'h11; bus.in1 = 8'h22; bus.in2 = 8'h33; bus.in3 = 8'h44;
    bus.ready_in = 1'b1;

    // Reset held two cycles with all lanes pushing
    step();
    chk_en = 1'b1;
    step();
    chk("rst valid_out", 32'(bus.valid_out), 32'h0);
    chk("rst fifo_empty", 32'(bus.fifo_empty), 32'hF);
    chk("rst overflow", 32'(bus.overflow), 32'h0);
    reset = 1'b0;
    bus.validin = 4'h0;
    step();
    chk("post-rst empty", 32'(bus.fifo_empty), 32'hF);
    chk("post-rst valid", 32'(bus.valid_out), 32'h0);

    // Round-robin across all four lanes
    bus.in0 = 8'hA0; bus.in1 = 8'hB1; bus.in2 = 8'hC2; bus.in3 = 8'hD3;
    bus.validin = 4'hF;
    step();
    bus.validin = 4'h0;
    chk("rr no bypass", 32'(bus.valid_out), 32'h0);
    step(); chk("rr byte0", {bus.valid_out, 6'h0, bus.lane_out, bus.data_out}, 32'h100A0);
    step(); chk("rr byte1", {bus.valid_out, 6'h0, bus.lane_out, bus.data_out}, 32'h101B1);
    step(); chk("rr byte2", {bus.valid_out, 6'h0, bus.lane_out, bus.data_out}, 32'h102C2);
    step(); chk("rr byte3", {bus.valid_out, 6'h0, bus.lane_out, bus.data_out}, 32'h103D3);
    step(); chk("rr drained", 32'(bus.valid_out), 32'h0);

    // Stall holds the output stable
    bus.in0 = 8'hA0; bus.in1 = 8'hB1; bus.validin = 4'b0011;
    step();
    bus.validin = 4'h0;
    step(); chk("stall first", {bus.lane_out, bus.data_out}, 32'h0A0);
    bus.ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(); chk("stall hold", {bus.valid_out, 6'h0, bus.lane_out, bus.data_out}, 32'h100A0);
    end
    bus.ready_in = 1'b1;
    step(); chk("stall release", {bus.lane_out, bus.data_out}, 32'h1B1);
    step(); chk("stall drained", 32'(bus.valid_out), 32'h0);

    // Overflow on lane 2 while output is stalled on a lane-0 byte
    bus.ready_in = 1'b0;
    bus.in0 = 8'h99; bus.validin = 4'b0001;
    step();
    bus.validin = 4'h0;
    step();
    for (int b = 0; b < 5; b++) begin
      bus.in2 = 8'(8'h10 + b);
      bus.validin = 4'b0100;
      step();
    end
    bus.validin = 4'h0;
    chk("ovf full2", 32'(bus.fifo_full[2]), 32'h1);
    chk("ovf flag2", 32'(bus.overflow[2]), 32'h1);
    chk("ovf held byte", 32'(bus.data_out), 32'h99);
    bus.ready_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step(); chk("ovf drain", {bus.lane_out, bus.data_out}, 32'(10'h210 + b));
    end
    step(); chk("ovf 14 lost", 32'(bus.valid_out), 32'h0);
    chk("ovf sticky", 32'(bus.overflow), 32'h4);

    // Full lane pushed while being popped
    bus.ready_in = 1'b0;
    bus.in0 = 8'h77; bus.validin = 4'b0001;
    step();
    for (int b = 0; b < 4; b++) begin
      bus.in1 = 8'(8'h20 + b);
      bus.validin = 4'b0010;
      step();
    end
    chk("fp full1", 32'(bus.fifo_full[1]), 32'h1);
    chk("fp held", 32'(bus.data_out), 32'h77);
    bus.ready_in = 1'b1;
    bus.in1 = 8'h55;
    step();
    bus.validin = 4'h0;
    chk("fp pop byte", {bus.lane_out, bus.data_out}, 32'h120);
    chk("fp still full", 32'(bus.fifo_full[1]), 32'h1);
    chk("fp no ovf1", 32'(bus.overflow[1]), 32'h0);
    step(); chk("fp 21", 32'(bus.data_out), 32'h21);
    step(); chk("fp 22", 32'(bus.data_out), 32'h22);
    step(); chk("fp 23", 32'(bus.data_out), 32'h23);
    step(); chk("fp 55", {bus.lane_out, bus.data_out}, 32'h155);
    step();

    // Lanes 0 and 3 kept non-empty: grants must alternate
    s0 = 8'h00; s3 = 8'h80; prev = 0;
    for (int it = 0; it < 48; it++) begin
      bus.validin = {(mq[3].size() < 2), 2'b00, (mq[0].size() < 2)};
      bus.in0 = s0; bus.in3 = s3;
      if (bus.validin[0]) s0++;
      if (bus.validin[3]) s3++;
      step();
      if (it >= 2) chk("alternate", 32'(bus.lane_out), (prev == 0) ? 32'd3 : 32'd0);
      if (it >= 1) prev = int'(bus.lane_out);
    end
    bus.validin = 4'h0;
    for (int c = 0; c < 6; c++) step();

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(199) == 0);
      bus.validin  = 4'($urandom);
      bus.ready_in = ($urandom_range(9) < 6);
      bus.in0 = 8'($urandom); bus.in1 = 8'($urandom);
      bus.in2 = 8'($urandom); bus.in3 = 8'($urandom);
      step();
    end
    reset = 1'b0;
    bus.validin = 4'h0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
